// File: rtl/bcd_converter_seq.sv
// Sequential binary-to-BCD converter (double-dabble, one bit per clock) with start/done handshake.
// Optional macro SIGNED_INPUT_EN adds signed_mode/sign for two's-complement inputs.
module bcd_converter_seq #(
  parameter int IN_WIDTH = 32,
  parameter int DIGITS   = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   number,
`ifdef SIGNED_INPUT_EN
  input  logic                  signed_mode,
  output logic                  sign,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  // Handshake: start is accepted on a rising edge only in IDLE or DONE; once
  // accepted, busy stays high until the last shift, and done pulses for exactly
  // one cycle together with fresh bcd/overflow. start during busy is dropped.
  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IN_WIDTH-1:0] bin;
  logic [BW-1:0]       work;
  logic                ovf_acc;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       work_next;
  logic                ovf_next;
  logic [IN_WIDTH-1:0] load_val;
`ifdef SIGNED_INPUT_EN
  logic                load_neg;
  logic                sign_acc;
`endif

  always_comb begin
    adj = work;
    for (int d = 0; d < DIGITS; d++) begin
      if (work[4*d +: 4] >= 4'd5) adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
    end
  end

  // The top bit leaving the BCD field is dropped; it only marks overflow.
  assign work_next = {adj[BW-2:0], bin[IN_WIDTH-1]};
  assign ovf_next  = ovf_acc | adj[BW-1];

`ifdef SIGNED_INPUT_EN
  assign load_neg = signed_mode & number[IN_WIDTH-1];
  assign load_val = load_neg ? (~number + {{(IN_WIDTH-1){1'b0}}, 1'b1}) : number;
`else
  assign load_val = number;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      bin      <= '0;
      work     <= '0;
      ovf_acc  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
`ifdef SIGNED_INPUT_EN
      sign_acc <= 1'b0;
      sign     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            bin     <= load_val;
            work    <= '0;
            ovf_acc <= 1'b0;
            cnt     <= CW'(IN_WIDTH);
            busy    <= 1'b1;
            state   <= SHIFT;
`ifdef SIGNED_INPUT_EN
            sign_acc <= load_neg;
`endif
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          work    <= work_next;
          bin     <= {bin[IN_WIDTH-2:0], 1'b0};
          ovf_acc <= ovf_next;
          cnt     <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            bcd      <= work_next;
            overflow <= ovf_next;
`ifdef SIGNED_INPUT_EN
            sign     <= sign_acc;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_converter_seq.sv
// Bench for bcd_converter_seq: a 32-bit/10-digit and a 16-bit/4-digit instance
// checked against an arithmetic (divide-by-ten) reference model.
module tb_bcd_converter_seq;

  logic        clk;
  logic        rst_n;
  logic        st;
  logic        sel;
  logic [31:0] num;
  logic        sm;
  logic        start32, start16;
  logic        busy32, done32, ovf32;
  logic        busy16, done16, ovf16;
  logic [39:0] bcd32;
  logic [15:0] bcd16;
  logic        sign32, sign16;
  logic        obs_busy, obs_done, obs_ovf, obs_sign;
  logic [39:0] obs_bcd;

  int checks = 0;
  int errors = 0;
  logic [39:0] exp_q[$];

  assign start32  = st & ~sel;
  assign start16  = st & sel;
  assign obs_busy = sel ? busy16 : busy32;
  assign obs_done = sel ? done16 : done32;
  assign obs_ovf  = sel ? ovf16 : ovf32;
  assign obs_bcd  = sel ? {24'b0, bcd16} : bcd32;
  assign obs_sign = sel ? sign16 : sign32;

  bcd_converter_seq #(.IN_WIDTH(32), .DIGITS(10)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .number(num),
`ifdef SIGNED_INPUT_EN
    .signed_mode(sm), .sign(sign32),
`endif
    .busy(busy32), .done(done32), .bcd(bcd32), .overflow(ovf32)
  );

  bcd_converter_seq #(.IN_WIDTH(16), .DIGITS(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .number(num[15:0]),
`ifdef SIGNED_INPUT_EN
    .signed_mode(sm), .sign(sign16),
`endif
    .busy(busy16), .done(done16), .bcd(bcd16), .overflow(ovf16)
  );

`ifndef SIGNED_INPUT_EN
  assign sign32 = 1'b0;
  assign sign16 = 1'b0;
`endif

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: value modulo 10^nd split into decimal digits; overflow when value >= 10^nd.
  function automatic void model(input logic [31:0] n, input int width, input int nd, input bit smode,
                                output logic [39:0] b, output bit ov, output bit sg);
    longint unsigned v, p;
    v  = (width == 16) ? longint'(n[15:0]) : longint'(n);
    sg = 1'b0;
    if (smode && n[width-1]) begin
      v  = (64'd1 << width) - v;
      sg = 1'b1;
    end
    p = 1;
    for (int i = 0; i < nd; i++) p = p * 10;
    ov = (v >= p);
    v  = v % p;
    b  = '0;
    for (int d = 0; d < nd; d++) begin
      b[4*d +: 4] = 4'(v % 10);
      v = v / 10;
    end
  endfunction

  // One conversion, called at a negedge; optional noise on start/number while busy.
  task automatic conv(input bit use16, input logic [31:0] n, input bit smode, input bit noise);
    int width, nd, c, busy_cnt;
    bit got, ov, sg;
    logic [39:0] eb;
    width = use16 ? 16 : 32;
    nd    = use16 ? 4 : 10;
    model(n, width, nd, smode, eb, ov, sg);
    sel = use16;
    st  = 1'b1;
    num = n;
    sm  = smode;
    @(negedge clk);
    st = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (noise) num = $urandom;
    c = 0; busy_cnt = 0; got = 1'b0;
    while (c <= width + 4 && !got) begin
      if (obs_done) got = 1'b1;
      else begin
        if (obs_busy) busy_cnt++;
        @(negedge clk);
        c++;
        if (noise && c < width) begin
          st  = 1'($urandom_range(0, 1));
          num = $urandom;
        end else st = 1'b0;
      end
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(c), 64'(width));
    check("busy_cycles", 64'(busy_cnt), 64'(width));
    check("busy_at_done", 64'(obs_busy), 64'd0);
    check("bcd", 64'(obs_bcd), 64'(eb));
    check("overflow", 64'(obs_ovf), 64'(ov));
`ifdef SIGNED_INPUT_EN
    check("sign", 64'(obs_sign), 64'(sg));
`endif
    st = 1'b0;
    @(negedge clk);
    check("done_pulse_end", 64'(obs_done), 64'd0);
    check("bcd_hold", 64'(obs_bcd), 64'(eb));
  endtask

  // start held high on the 32-bit instance; number changes every cycle.
  task automatic back_to_back(input int nconv);
    int c, seen;
    bit ov, sg;
    logic [39:0] eb, en;
    sel = 1'b0; sm = 1'b0;
    st  = 1'b1;
    num = $urandom;
    exp_q.push_back({8'b0, num});
    c = -1; seen = 0;
    while (seen < nconv && c < 40 * nconv) begin
      @(negedge clk);
      c++;
      check("b2b_done", 64'(done32), 64'((c % 33) == 32));
      if (done32) begin
        seen++;
        en = exp_q.pop_front();
        model(en[31:0], 32, 10, 1'b0, eb, ov, sg);
        check("b2b_bcd", 64'(bcd32), 64'(eb));
        check("b2b_ovf", 64'(ovf32), 64'(ov));
      end
      if (seen == nconv) st = 1'b0;
      else begin
        num = $urandom;
        if (((c + 1) % 33) == 0) exp_q.push_back({8'b0, num});
      end
    end
    check("b2b_count", 64'(seen), 64'(nconv));
    @(negedge clk);
    check("b2b_idle", 64'(busy32 | done32), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy32"}, 64'(busy32), 64'd0);
    check({tag, "_done32"}, 64'(done32), 64'd0);
    check({tag, "_bcd32"}, 64'(bcd32), 64'd0);
    check({tag, "_ovf32"}, 64'(ovf32), 64'd0);
    check({tag, "_bcd16"}, 64'(bcd16), 64'd0);
    check({tag, "_ovf16"}, 64'(ovf16), 64'd0);
    check({tag, "_sign32"}, 64'(sign32), 64'd0);
  endtask

  initial begin
    int dones;
    logic [31:0] r;
    rst_n = 1'b1; st = 1'b0; sel = 1'b0; num = '0; sm = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // directed 32-bit cases
    conv(1'b0, 32'd0, 1'b0, 1'b0);
    conv(1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    check("max32_const", 64'(bcd32), 64'h42_9496_7295);
    conv(1'b0, 32'd999_999_999, 1'b0, 1'b0);
    conv(1'b0, 32'd1_000_000_000, 1'b0, 1'b0);
    conv(1'b0, 32'd5, 1'b0, 1'b0);

    // directed 16-bit / 4-digit cases incl. overflow boundary
    conv(1'b1, 32'd12345, 1'b0, 1'b0);
    check("ovf16_const", 64'({ovf16, bcd16}), 64'h1_2345);
    conv(1'b1, 32'd9999, 1'b0, 1'b0);
    check("max4_const", 64'({ovf16, bcd16}), 64'h0_9999);
    conv(1'b1, 32'd10000, 1'b0, 1'b0);
    conv(1'b1, 32'd65535, 1'b0, 1'b0);

    // random conversions, some with noise while busy
    for (int i = 0; i < 16; i++) conv(1'b0, $urandom, 1'b0, i[0]);
    for (int i = 0; i < 12; i++) conv(1'b1, 32'($urandom_range(0, 65535)), 1'b0, i[0]);

    back_to_back(4);

    // abort mid-conversion after 10 shifts
    sel = 1'b0; st = 1'b1; num = $urandom;
    @(negedge clk);
    st = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done32) dones++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    conv(1'b0, 32'd1234, 1'b0, 1'b0);
    check("after_abort_const", 64'(bcd32), 64'h00_0000_1234);

`ifdef SIGNED_INPUT_EN
    conv(1'b0, 32'hFFFF_FFFB, 1'b1, 1'b0);
    check("neg5_const", 64'({sign32, bcd32}), 64'h1_00_0000_0005);
    conv(1'b0, 32'h8000_0000, 1'b1, 1'b0);
    check("minint_const", 64'({sign32, bcd32}), 64'h1_21_4748_3648);
    conv(1'b0, 32'hFFFF_FFFB, 1'b0, 1'b0);
    check("unsigned_const", 64'({sign32, bcd32}), 64'h0_42_9496_7291);
    conv(1'b1, 32'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      r = $urandom;
      conv(i[1], r, i[0], 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
